// File: rtl/vr_stream_source.sv
// vr_stream_source: valid/ready traffic generator emitting an arithmetic beat sequence per command
module vr_stream_source #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [GAP_W-1:0] cmd_gap,
  output logic [WIDTH-1:0] data_out,
  output logic             dn_valid_out,
  output logic             dn_last_out,
  input  logic             dn_ready_in,
  output logic             busy,
  output logic             done_pulse,
  output logic [LEN_W-1:0] sent_count
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;
  logic [LEN_W-1:0] len, len_n, cnt_n;
  logic [WIDTH-1:0] step, step_n, data_n;
  logic [GAP_W-1:0] gap, gap_n, gcnt, gcnt_n;
  logic valid_n, last_n, busy_n, done_n;
  assign cmd_ready = (state == IDLE) && !rst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      step         <= '0;
      gap          <= '0;
      gcnt         <= '0;
      data_out     <= '0;
      dn_valid_out <= 1'b0;
      dn_last_out  <= 1'b0;
      busy         <= 1'b0;
      done_pulse   <= 1'b0;
      sent_count   <= '0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      step         <= step_n;
      gap          <= gap_n;
      gcnt         <= gcnt_n;
      data_out     <= data_n;
      dn_valid_out <= valid_n;
      dn_last_out  <= last_n;
      busy         <= busy_n;
      done_pulse   <= done_n;
      sent_count   <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    len_n   = len;
    step_n  = step;
    gap_n   = gap;
    gcnt_n  = gcnt;
    data_n  = data_out;
    valid_n = dn_valid_out;
    last_n  = dn_last_out;
    busy_n  = busy;
    done_n  = 1'b0;
    cnt_n   = sent_count;
    if (state == IDLE) begin
      if (cmd_valid) begin
        len_n   = cmd_len;
        step_n  = cmd_step;
        gap_n   = cmd_gap;
        data_n  = cmd_seed;
        cnt_n   = '0;
        valid_n = cmd_len != '0;
        busy_n  = cmd_len != '0;
        done_n  = cmd_len == '0;
        last_n  = cmd_len == LEN_W'(1);
        state_n = (cmd_len != '0) ? SEND : IDLE;
      end
    end else if (state == SEND) begin
      if (dn_ready_in) begin
        cnt_n  = sent_count + LEN_W'(1);
        data_n = data_out + step;
        if (dn_last_out) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (gap == '0) begin
          last_n = cnt_n == len - LEN_W'(1);
        end else begin
          state_n = GAP;
          valid_n = 1'b0;
          gcnt_n  = gap;
        end
      end
    end else begin
      gcnt_n = gcnt - GAP_W'(1);
      if (gcnt == GAP_W'(1)) begin
        state_n = SEND;
        valid_n = 1'b1;
        last_n  = sent_count == len - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_vr_stream_source.sv
// tb_vr_stream_source: scoreboard bench for vr_stream_source beats, timing, stalls and reset
module tb_vr_stream_source;
  localparam int W = 32;
  localparam int LW = 16;
  localparam int GW = 4;
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [W-1:0] cmd_seed = '0, cmd_step = '0;
  logic [GW-1:0] cmd_gap = '0;
  logic [W-1:0] data_out;
  logic dn_valid_out, dn_last_out, dn_ready_in = 1'b0, busy, done_pulse;
  logic [LW-1:0] sent_count;
  beat_t q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, cmd_cyc = 0, first_cyc = 0, last_cyc = 0, fires = 0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic prev_last;
  vr_stream_source #(.WIDTH(W), .LEN_W(LW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed), .cmd_step(cmd_step), .cmd_gap(cmd_gap),
    .data_out(data_out), .dn_valid_out(dn_valid_out), .dn_last_out(dn_last_out),
    .dn_ready_in(dn_ready_in), .busy(busy), .done_pulse(done_pulse), .sent_count(sent_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
      fires = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        cmd_cyc = cyc;
        fires = 0;
      end
      if (prev_stall) begin
        n_checks++;
        if (dn_valid_out !== 1'b1 || data_out !== prev_data || dn_last_out !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", dn_valid_out, data_out, dn_last_out, prev_data, prev_last);
        end
      end
      if (dn_valid_out && dn_ready_in) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got d=%h l=%b want no beat", data_out, dn_last_out);
        end else begin
          e = q.pop_front();
          if (data_out !== e.d || dn_last_out !== e.l) begin
            n_fail++;
            $display("FAIL beat: got d=%h l=%b want d=%h l=%b", data_out, dn_last_out, e.d, e.l);
          end
        end
        if (fires == 0) first_cyc = cyc;
        last_cyc = cyc;
        fires++;
      end
      prev_stall = dn_valid_out && !dn_ready_in;
      prev_data = data_out;
      prev_last = dn_last_out;
    end
  end
  task automatic issue(input int len, input logic [W-1:0] seed, input logic [W-1:0] step, input int gap);
    beat_t b;
    logic [W-1:0] d;
    @(posedge clk);
    #1;
    cmd_len = LW'(len);
    cmd_seed = seed;
    cmd_step = step;
    cmd_gap = GW'(gap);
    cmd_valid = 1'b1;
    d = seed;
    for (int k = 0; k < len; k++) begin
      b.d = d;
      b.l = (k == len - 1);
      q.push_back(b);
      d = d + step;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic wait_done(input int bound, output bit ok, output int dcyc);
    ok = 1'b0;
    dcyc = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_pulse) begin
        ok = 1'b1;
        dcyc = cyc;
        return;
      end
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({data_out, dn_valid_out, dn_last_out, busy, done_pulse, sent_count, cmd_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got d=%h v=%b l=%b b=%b dp=%b sc=%0d cr=%b want all 0", data_out, dn_valid_out, dn_last_out, busy, done_pulse, sent_count, cmd_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask
  task automatic test_basic();
    bit ok;
    int dcyc;
    dn_ready_in = 1'b1;
    issue(4, 32'h10, 32'h1, 0);
    n_checks++;
    if (dn_valid_out !== 1'b1 || data_out !== 32'h10 || dn_last_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_first: got v=%b d=%h l=%b b=%b want v=1 d=10 l=0 b=1", dn_valid_out, data_out, dn_last_out, busy);
    end
    wait_done(50, ok, dcyc);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_done_timeout: got no done_pulse want done_pulse");
    end
    n_checks++;
    if (fires !== 4 || first_cyc - cmd_cyc !== 1 || last_cyc - first_cyc !== 3 || dcyc - last_cyc !== 1) begin
      n_fail++;
      $display("FAIL basic_timing: got fires=%0d lat=%0d span=%0d done=%0d want 4 1 3 1", fires, first_cyc - cmd_cyc, last_cyc - first_cyc, dcyc - last_cyc);
    end
    n_checks++;
    if (sent_count !== 16'd4 || cmd_ready !== 1'b1 || busy !== 1'b0 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL basic_end: got sc=%0d cr=%b b=%b q=%0d want 4 1 0 0", sent_count, cmd_ready, busy, q.size());
    end
    @(negedge clk);
    n_checks++;
    if (done_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got %b want 0", done_pulse);
    end
  endtask
  task automatic test_gap();
    bit ok;
    int dcyc;
    dn_ready_in = 1'b1;
    issue(3, 32'hFFFF_FFFE, 32'h1, 2);
    wait_done(50, ok, dcyc);
    n_checks++;
    if (!ok || fires !== 3 || first_cyc - cmd_cyc !== 1 || last_cyc - first_cyc !== 6 || dcyc - last_cyc !== 1) begin
      n_fail++;
      $display("FAIL gap_timing: got ok=%b fires=%0d lat=%0d span=%0d done=%0d want 1 3 1 6 1", ok, fires, first_cyc - cmd_cyc, last_cyc - first_cyc, dcyc - last_cyc);
    end
    n_checks++;
    if (sent_count !== 16'd3 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL gap_end: got sc=%0d q=%0d want 3 0", sent_count, q.size());
    end
  endtask
  task automatic test_stall();
    bit got;
    logic prev;
    dn_ready_in = 1'b1;
    issue(5, 32'h100, 32'h7, 0);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_pulse) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      dn_ready_in = (i % 4 == 0) || (i % 4 == 3);
    end
    n_checks++;
    if (!got || fires !== 5 || sent_count !== 16'd5 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_pattern: got done=%b fires=%0d sc=%0d q=%0d want 1 5 5 0", got, fires, sent_count, q.size());
    end
    dn_ready_in = 1'b0;
    issue(4, 32'hABC, 32'h100, 1);
    prev = dn_valid_out;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_pulse) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      dn_ready_in = prev;
      prev = dn_valid_out;
    end
    n_checks++;
    if (!got || fires !== 4 || sent_count !== 16'd4 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_lagged: got done=%b fires=%0d sc=%0d q=%0d want 1 4 4 0", got, fires, sent_count, q.size());
    end
  endtask
  task automatic test_len0();
    dn_ready_in = 1'b1;
    issue(0, 32'h55, 32'h1, 0);
    @(negedge clk);
    n_checks++;
    if (done_pulse !== 1'b1 || cmd_ready !== 1'b1 || dn_valid_out !== 1'b0 || sent_count !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0: got dp=%b cr=%b v=%b sc=%0d b=%b want 1 1 0 0 0", done_pulse, cmd_ready, dn_valid_out, sent_count, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done_pulse !== 1'b0 || dn_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_after: got dp=%b v=%b want 0 0", done_pulse, dn_valid_out);
    end
  endtask
  task automatic test_back_to_back();
    beat_t b;
    logic [W-1:0] d;
    bit got, ok;
    int dcyc;
    dn_ready_in = 1'b1;
    @(posedge clk);
    #1;
    cmd_len = 16'd2;
    cmd_seed = 32'h500;
    cmd_step = 32'h3;
    cmd_gap = '0;
    cmd_valid = 1'b1;
    d = 32'h500;
    for (int k = 0; k < 2; k++) begin
      b.d = d;
      b.l = (k == 1);
      q.push_back(b);
      d = d + 32'h3;
    end
    @(posedge clk);
    #1;
    cmd_len = 16'd3;
    cmd_seed = 32'h900;
    cmd_step = 32'hFFFF_FFFF;
    cmd_gap = 4'd1;
    d = 32'h900;
    for (int k = 0; k < 3; k++) begin
      b.d = d;
      b.l = (k == 2);
      q.push_back(b);
      d = d + 32'hFFFF_FFFF;
    end
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || done_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: got ready=%b dp=%b want 1 1", got, done_pulse);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dn_valid_out !== 1'b1 || data_out !== 32'h900) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b d=%h want v=1 d=900", dn_valid_out, data_out);
    end
    wait_done(50, ok, dcyc);
    n_checks++;
    if (!ok || sent_count !== 16'd3 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_end: got ok=%b sc=%0d q=%0d want 1 3 0", ok, sent_count, q.size());
    end
  endtask
  task automatic test_reset_mid();
    bit got, ok;
    int dcyc;
    int seen_done;
    dn_ready_in = 1'b1;
    issue(6, 32'h40, 32'h2, 3);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (fires == 1 && !dn_valid_out) begin
        dn_ready_in = 1'b0;
        got = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 50 && got; i++) begin
      @(negedge clk);
      if (dn_valid_out) break;
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (!got || {data_out, dn_valid_out, dn_last_out, busy, done_pulse, sent_count, cmd_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got ok=%b d=%h v=%b l=%b b=%b dp=%b sc=%0d cr=%b want all 0", got, data_out, dn_valid_out, dn_last_out, busy, done_pulse, sent_count, cmd_ready);
    end
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_pulse || dn_valid_out) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen_done);
    end
    dn_ready_in = 1'b1;
    issue(3, 32'h77, 32'h5, 1);
    n_checks++;
    if (data_out !== 32'h77 || dn_valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got v=%b d=%h want v=1 d=77", dn_valid_out, data_out);
    end
    wait_done(50, ok, dcyc);
    n_checks++;
    if (!ok || fires !== 3 || sent_count !== 16'd3 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_end: got ok=%b fires=%0d sc=%0d q=%0d want 1 3 3 0", ok, fires, sent_count, q.size());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_stall();
    test_len0();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vr_stream_source.md
# vr_stream_source

Valid/ready transmitter that originates a stream into a chain of pipeline nodes: it accepts one command (length, seed, step, inter-beat gap), emits an arithmetic data sequence on a downstream valid/ready port, flags the final beat, and pulses done. It sits at the head of a node chain as the traffic generator for ready-latency and throughput experiments. It must tolerate arbitrary downstream ready behaviour, including ready that lags by a cycle and stalls of any length.

## Interface
Parameters:
- WIDTH, 32, data width; data arithmetic is modulo 2^WIDTH
- LEN_W, 16, width of beat-count fields
- GAP_W, 4, width of the idle-gap field

Ports:
- clk  input  1  single clock, all logic on posedge
- rst  input  1  reset, asynchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  source can accept a command
- cmd_len  input  LEN_W  number of beats, 0 allowed
- cmd_seed  input  WIDTH  data of beat 0
- cmd_step  input  WIDTH  increment added per beat
- cmd_gap  input  GAP_W  idle cycles inserted after each non-final fired beat
- data_out  output  WIDTH  beat data
- dn_valid_out  output  1  beat valid, to downstream
- dn_last_out  output  1  marks final beat, qualified by dn_valid_out
- dn_ready_in  input  1  downstream ready
- busy  output  1  high from command accept until final beat fires
- done_pulse  output  1  one-cycle pulse after stream completes
- sent_count  output  LEN_W  beats fired in current/last stream

## Operation
- cmd_fire = cmd_valid & cmd_ready; dn_fire = dn_valid_out & dn_ready_in.
- States: IDLE, SEND, GAP. cmd_ready = (state == IDLE); forced 0 while rst is asserted.
- IDLE: on cmd_fire latch len, step, gap; data_out <= cmd_seed; sent_count <= 0. If cmd_len == 0: stay IDLE, done_pulse next cycle, no beat emitted. Else -> SEND with dn_valid_out=1, dn_last_out=(cmd_len==1), busy=1.
- SEND: data_out, dn_last_out and dn_valid_out held stable until dn_fire; valid never drops without a fire. On dn_fire: sent_count +1; data_out <= data_out + step (wraps).
  - final beat (sent_count == len-1): -> IDLE, dn_valid_out=0, dn_last_out=0, busy=0, done_pulse=1 for one cycle.
  - else if gap == 0: stay SEND, valid stays high, next beat presented the very next cycle.
  - else: -> GAP, dn_valid_out=0, gap counter loaded with gap.
- GAP: counter decrements each cycle; at expiry -> SEND with valid high. dn_ready_in ignored.
- dn_last_out asserts together with the final beat's valid and is held with it.
- New command cannot be accepted before done_pulse; cmd_ready rises in the same cycle as done_pulse.
- Reset at any point, including mid-beat or mid-gap: stream abandoned, no done_pulse; all registers cleared.

## Timing
- Reset values: data_out=0, dn_valid_out=0, dn_last_out=0, busy=0, done_pulse=0, sent_count=0, state IDLE; cmd_ready=1 from first cycle after rst deasserts.
- All outputs except cmd_ready are registered.
- Command-to-first-valid latency: 1 cycle after cmd_fire edge.
- gap=0, ready held high: one beat per cycle, N beats in N cycles.
- gap=G, ready held high: beat period G+1 cycles; total stream = N + (N-1)*G cycles.
- Final dn_fire to done_pulse: 1 cycle; next cmd_fire possible in the done_pulse cycle.
- Stall of any length: outputs frozen, no beat dropped or duplicated.

## Test plan
- Reset then cmd len=4, seed=0x10, step=1, gap=0, ready=1 -> data 0x10,0x11,0x12,0x13 on 4 consecutive cycles, last on 0x13, done_pulse 1 cycle later, sent_count=4.
- len=3, seed=0xFFFFFFFE, step=1, gap=2 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x0; valid low exactly 2 cycles between beats; last on 0x0.
- len=5, gap=0, ready toggling 1,0,0,1,… plus one-cycle-lagged ready pattern -> exactly 5 fires, values seed+k*step in order, data/last stable while valid&!ready.
- cmd len=0 -> no dn_valid_out, done_pulse 1 cycle after accept, cmd_ready stays 1, sent_count=0.
- Back-to-back commands: second cmd_valid held high from start -> accepted in done_pulse cycle; its first beat appears next cycle.
- Assert rst during beat 2 of a 6-beat gap=3 stream -> all outputs 0 immediately, no done_pulse; fresh cmd afterwards runs cleanly from its seed.
